// File: rtl/data_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_like_bridge
//   Converts the CPU core's single-cycle data-SRAM port into a sram-like bus.
//   The bridge runs one transaction at a time and holds the pipeline stalled
//   until that transaction completes.
//
//   Optional feature: define DSB_TIMEOUT_EN to abort a transaction that spends
//   TIMEOUT_CYC cycles in REQ+WAIT. An aborted transaction returns zero data
//   and sets the sticky bus_err flag. Without the macro the bridge waits
//   indefinitely and bus_err is tied low.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   cpu_en/wen/addr/wdata CPU access request (held stable while cpu_stall=1)
//   cpu_rdata            load word, valid in DONE and held until the next DONE
//   cpu_stall            pipeline freeze
//   req/wr/size/addr/wdata sram-like request channel, addr_ok = accept
//   data_ok/rdata        sram-like response channel
//   bus_err              sticky timeout flag
// -----------------------------------------------------------------------------
module data_sram_like_bridge #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        wr_enc;
    logic [1:0]  size_enc;
    logic [31:0] addr_enc;
    logic        tmo;

    // Transfer size from the byte-enable pattern; unrecognised patterns are
    // treated as a full word.
    function automatic logic [1:0] enc_size(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: enc_size = 2'd0;
            4'b0011, 4'b1100:                   enc_size = 2'd1;
            default:                            enc_size = 2'd2;
        endcase
    endfunction

    // Low address bits come from the lane that is enabled, not from cpu_addr.
    function automatic logic [1:0] enc_off(input logic [3:0] wen);
        case (wen)
            4'b0010:          enc_off = 2'b01;
            4'b0100, 4'b1100: enc_off = 2'b10;
            4'b1000:          enc_off = 2'b11;
            default:          enc_off = 2'b00;
        endcase
    endfunction

    assign wr_enc   = |cpu_wen;
    assign size_enc = enc_size(cpu_wen);
    assign addr_enc = {cpu_addr[31:2], enc_off(cpu_wen)};

    assign cpu_stall = cpu_en & (state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the encoded request every IDLE cycle so REQ can replay it
    // unchanged while the bus keeps us waiting for addr_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (state == S_IDLE) begin
            wr_q    <= wr_enc;
            size_q  <= size_enc;
            addr_q  <= addr_enc;
            wdata_q <= cpu_wdata;
        end
    end

    // Writes also capture rdata so cpu_rdata always reflects the last response.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata <= 32'h0;
        end else if (tmo) begin
            cpu_rdata <= 32'h0;
        end else if (state == S_WAIT && data_ok) begin
            cpu_rdata <= rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        wr        = wr_q;
        size      = size_q;
        addr      = addr_q;
        wdata     = wdata_q;
        case (state)
            S_IDLE: begin
                req   = cpu_en;
                wr    = wr_enc;
                size  = size_enc;
                addr  = addr_enc;
                wdata = cpu_wdata;
                if (cpu_en) begin
                    state_nxt = addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // req is withdrawn in the abort cycle so no handshake is lost.
                req = !tmo;
                if (tmo || addr_ok) begin
                    state_nxt = tmo ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (tmo || data_ok) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef DSB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic             bus_err_q;

    // cnt counts completed REQ/WAIT cycles; the abort fires in the cycle that
    // would make it reach TIMEOUT_CYC, so exactly TIMEOUT_CYC cycles are spent
    // in REQ+WAIT before DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state == S_REQ || state == S_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            if (tmo) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign tmo     = (state == S_REQ || state == S_WAIT) && (cnt == TMO_LAST);
    assign bus_err = bus_err_q;
`else
    logic unused_cfg;

    assign tmo        = 1'b0;
    assign bus_err    = 1'b0;
    assign unused_cfg = ^{TIMEOUT_CYC, CNT_W};
`endif

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

endmodule

// File: tb/tb_data_sram_like_bridge.sv
module tb_data_sram_like_bridge;

    localparam int TMO = 6;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    data_sram_like_bridge #(
        .TIMEOUT_CYC (TMO),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b required 0", req); end
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b required 0", cpu_stall); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h required 0", cpu_rdata); end
        n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_bus_err: got %b required 0", bus_err); end
        next_cycle();
    endtask

    task automatic test_read_zero_wait();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1000_0006; addr_ok = 1'b1;
        @(negedge clk);
        n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL rd_req: got %b required 1", req); end
        n_vec++; if (addr !== 32'h1000_0004) begin n_err++; $display("FAIL rd_addr: got %h required 10000004", addr); end
        n_vec++; if (size !== 2'd2) begin n_err++; $display("FAIL rd_size: got %0d required 2", size); end
        n_vec++; if (wr !== 1'b0) begin n_err++; $display("FAIL rd_wr: got %b required 0", wr); end
        n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL rd_stall_c0: got %b required 1", cpu_stall); end
        next_cycle();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hA5A5_1234;
        @(negedge clk);
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL rd_req_wait: got %b required 0", req); end
        n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL rd_stall_c1: got %b required 1", cpu_stall); end
        next_cycle();
        data_ok = 1'b0;
        @(negedge clk);
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rd_stall_c2: got %b required 0", cpu_stall); end
        n_vec++; if (cpu_rdata !== 32'hA5A5_1234) begin n_err++; $display("FAIL rd_data: got %h required a5a51234", cpu_rdata); end
        next_cycle();
        cpu_en = 1'b0;
    endtask

    task automatic test_byte_store();
        int reqs;
        reqs = 0;
        cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h2000_0000; cpu_wdata = 32'h00CC_0000;
        for (int i = 0; i < 4; i++) begin
            addr_ok = (i == 3);
            // Perturb the CPU side while in REQ: the bus must replay the latched request.
            if (i == 1) begin
                cpu_addr = 32'h3000_0000; cpu_wdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (req === 1'b1) reqs++;
            n_vec++; if (wr !== 1'b1) begin n_err++; $display("FAIL bs_wr_%0d: got %b required 1", i, wr); end
            n_vec++; if (size !== 2'd0) begin n_err++; $display("FAIL bs_size_%0d: got %0d required 0", i, size); end
            n_vec++; if (addr !== 32'h2000_0002) begin n_err++; $display("FAIL bs_addr_%0d: got %h required 20000002", i, addr); end
            n_vec++; if (wdata !== 32'h00CC_0000) begin n_err++; $display("FAIL bs_wdata_%0d: got %h required 00cc0000", i, wdata); end
            next_cycle();
        end
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_2222;
        @(negedge clk);
        if (req === 1'b1) reqs++;
        n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL bs_stall_wait: got %b required 1", cpu_stall); end
        next_cycle();
        data_ok = 1'b0;
        @(negedge clk);
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL bs_stall_done: got %b required 0", cpu_stall); end
        n_vec++; if (cpu_rdata !== 32'h1111_2222) begin n_err++; $display("FAIL bs_rdata: got %h required 11112222", cpu_rdata); end
        n_vec++; if (reqs !== 4) begin n_err++; $display("FAIL bs_req_cycles: got %0d required 4", reqs); end
        next_cycle();
        cpu_en = 1'b0;
    endtask

    task automatic test_half_and_illegal();
        cpu_en = 1'b1; cpu_wen = 4'b1100; cpu_addr = 32'h4000_0001; cpu_wdata = 32'hABCD_0000; addr_ok = 1'b1;
        @(negedge clk);
        n_vec++; if (size !== 2'd1) begin n_err++; $display("FAIL hw_size: got %0d required 1", size); end
        n_vec++; if (addr !== 32'h4000_0002) begin n_err++; $display("FAIL hw_addr: got %h required 40000002", addr); end
        n_vec++; if (wr !== 1'b1) begin n_err++; $display("FAIL hw_wr: got %b required 1", wr); end
        next_cycle();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0;
        next_cycle();
        data_ok = 1'b0;
        @(negedge clk);
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL hw_stall_done: got %b required 0", cpu_stall); end
        next_cycle();
        cpu_wen = 4'b0101; cpu_addr = 32'h5000_0003; cpu_wdata = 32'h0055_0055; addr_ok = 1'b1;
        @(negedge clk);
        n_vec++; if (size !== 2'd2) begin n_err++; $display("FAIL il_size: got %0d required 2", size); end
        n_vec++; if (addr !== 32'h5000_0000) begin n_err++; $display("FAIL il_addr: got %h required 50000000", addr); end
        n_vec++; if (wdata !== 32'h0055_0055) begin n_err++; $display("FAIL il_wdata: got %h required 00550055", wdata); end
        next_cycle();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0;
        next_cycle();
        data_ok = 1'b0;
        next_cycle();
        cpu_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int hs;
        hs = 0;
        // addr_ok held high throughout: only cycles with req=1 may count.
        addr_ok = 1'b1;
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h6000_0008;
        @(negedge clk); if (req && addr_ok) hs++;
        next_cycle();
        data_ok = 1'b1; rdata = 32'h0BAD_CAFE;
        @(negedge clk); if (req && addr_ok) hs++;
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL b2b_req_wait: got %b required 0", req); end
        next_cycle();
        data_ok = 1'b0;
        @(negedge clk); if (req && addr_ok) hs++;
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL b2b_req_done: got %b required 0", req); end
        n_vec++; if (cpu_rdata !== 32'h0BAD_CAFE) begin n_err++; $display("FAIL b2b_rdata: got %h required 0badcafe", cpu_rdata); end
        next_cycle();
        cpu_wen = 4'b1111; cpu_addr = 32'h6000_000C; cpu_wdata = 32'h1234_5678;
        @(negedge clk); if (req && addr_ok) hs++;
        n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL b2b_req_wr: got %b required 1", req); end
        n_vec++; if (wr !== 1'b1) begin n_err++; $display("FAIL b2b_wr: got %b required 1", wr); end
        n_vec++; if (addr !== 32'h6000_000C) begin n_err++; $display("FAIL b2b_addr: got %h required 6000000c", addr); end
        next_cycle();
        data_ok = 1'b1; rdata = 32'h0;
        @(negedge clk); if (req && addr_ok) hs++;
        next_cycle();
        data_ok = 1'b0;
        @(negedge clk); if (req && addr_ok) hs++;
        next_cycle();
        cpu_en = 1'b0; addr_ok = 1'b0;
        @(negedge clk); if (req && addr_ok) hs++;
        n_vec++; if (hs !== 2) begin n_err++; $display("FAIL b2b_handshakes: got %0d required 2", hs); end
        next_cycle();
    endtask

    task automatic test_reset_in_wait();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h7000_0000; addr_ok = 1'b1;
        next_cycle();
        addr_ok = 1'b0;
        @(negedge clk);
        n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL rw_stall_wait: got %b required 1", cpu_stall); end
        next_cycle();
        rst = 1'b1; cpu_en = 1'b0;
        next_cycle();
        rst = 1'b0; data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rw_rdata_rst: got %h required 0", cpu_rdata); end
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rw_stall: got %b required 0", cpu_stall); end
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL rw_req: got %b required 0", req); end
        next_cycle();
        data_ok = 1'b0;
        @(negedge clk);
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rw_stray_ignored: got %h required 0", cpu_rdata); end
        // New read; a stray data_ok while in REQ must not complete it.
        cpu_en = 1'b1; cpu_addr = 32'h7000_0010;
        @(negedge clk);
        n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL rw_req_idle: got %b required 1", req); end
        next_cycle();
        data_ok = 1'b1; rdata = 32'hDEAD_0000;
        @(negedge clk);
        n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL rw_req_stray: got %b required 1", req); end
        next_cycle();
        data_ok = 1'b0; addr_ok = 1'b1;
        @(negedge clk);
        n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL rw_req_after_stray: got %b required 1", req); end
        next_cycle();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h600D_F00D;
        next_cycle();
        data_ok = 1'b0;
        @(negedge clk);
        n_vec++; if (cpu_rdata !== 32'h600D_F00D) begin n_err++; $display("FAIL rw_rdata: got %h required 600df00d", cpu_rdata); end
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rw_stall_done: got %b required 0", cpu_stall); end
        next_cycle();
        cpu_en = 1'b0;
    endtask

    task automatic test_timeout();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h8000_0000; addr_ok = 1'b0;
        @(negedge clk);
        n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL to_req_idle: got %b required 1", req); end
        next_cycle();
`ifdef DSB_TIMEOUT_EN
        // TMO cycles in REQ; req withdrawn in the last one, then DONE.
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            n_vec++; if (req !== (i != TMO - 1)) begin n_err++; $display("FAIL to_req_%0d: got %b required %b", i, req, (i != TMO - 1)); end
            n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL to_stall_%0d: got %b required 1", i, cpu_stall); end
            next_cycle();
        end
        @(negedge clk);
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL to_stall_done: got %b required 0", cpu_stall); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL to_rdata: got %h required 0", cpu_rdata); end
        n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err: got %b required 1", bus_err); end
        next_cycle();
        cpu_en = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err_sticky: got %b required 1", bus_err); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_bus_err_rst: got %b required 0", bus_err); end
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++; if (req !== 1'b1 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL nt_hold_%0d: got req=%b stall=%b required 1/1", i, req, cpu_stall); end
            next_cycle();
        end
        @(negedge clk);
        n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL nt_bus_err: got %b required 0", bus_err); end
        n_vec++; if (cpu_rdata !== 32'h600D_F00D) begin n_err++; $display("FAIL nt_rdata_held: got %h required 600df00d", cpu_rdata); end
        addr_ok = 1'b1;
        next_cycle();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0000_0BB8;
        next_cycle();
        data_ok = 1'b0;
        @(negedge clk);
        n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL nt_stall_done: got %b required 0", cpu_stall); end
        n_vec++; if (cpu_rdata !== 32'h0000_0BB8) begin n_err++; $display("FAIL nt_rdata: got %h required 00000bb8", cpu_rdata); end
        next_cycle();
        cpu_en = 1'b0;
`endif
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_byte_store();
        test_half_and_illegal();
        test_back_to_back();
        test_reset_in_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
